// File: rtl/code_counter_bank.sv
// Bank of CHANNELS prescaled event counters; channel k counts once per 4^k
// enabled, selected cycles, with wrap/saturate overflow and sticky flags.
module code_counter_chan #(
  parameter int WIDTH = 64,
  parameter int PW    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);
  logic evt;

  // Channel 0 has no prescaler: every enabled cycle is a count event.
  generate
    if (PW == 0) begin : g_nopre
      assign evt = en;
    end else begin : g_pre
      logic [PW-1:0] pre;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)              pre <= '0;
        else if (act && clr)  pre <= '0;
        else if (act && en)   pre <= pre + PW'(1);
      end
      assign evt = en && (pre == {PW{1'b1}});
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (act) begin
      if (clr) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (evt) begin
        if (count == {WIDTH{1'b1}}) begin
          ovf <= 1'b1;
          if (!mode) count <= '0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end
endmodule

module code_counter_bank #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      En,
  input  logic [SEL_W-1:0]          Slt,
  input  logic                      Clr,
  input  logic                      Mode,
  output logic [CHANNELS*WIDTH-1:0] Output,
  output logic [CHANNELS-1:0]       Ovf
);
  logic [CHANNELS-1:0][WIDTH-1:0] cnt;
  logic [CHANNELS-1:0]            act;

  // An out-of-range Slt matches no channel, so the cycle is a no-op.
  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign act[k] = (Slt == SEL_W'(k));
      code_counter_chan #(.WIDTH(WIDTH), .PW(2*k)) u_ch (
        .clk   (Clk),
        .rst   (Reset),
        .act   (act[k]),
        .en    (En),
        .clr   (Clr),
        .mode  (Mode),
        .count (cnt[k]),
        .ovf   (Ovf[k])
      );
    end
  endgenerate

  assign Output = cnt;
endmodule

// File: tb/tb_code_counter_bank.sv
// Scoreboard bench for code_counter_bank (WIDTH=4, CHANNELS=2, SEL_W=2).
module tb_code_counter_bank;
  logic       Clk = 1'b0;
  logic       Reset, En, Clr, Mode;
  logic [1:0] Slt;
  logic [7:0] Output;
  logic [1:0] Ovf;

  code_counter_bank #(.WIDTH(4), .CHANNELS(2), .SEL_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt), .Clr(Clr), .Mode(Mode),
    .Output(Output), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic [7:0] out;
    logic [1:0] ovf;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  event async_ev;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic void compare(input exp_t e, input int at);
    checks++;
    if (e.cyc != at || Output !== e.out || Ovf !== e.ovf) begin
      failures++;
      $display("FAIL %s: cyc=%0d Output=%h Ovf=%b, required cyc=%0d Output=%h Ovf=%b",
               e.name, at, Output, Ovf, e.cyc, e.out, e.ovf);
    end
  endfunction

  // Clocked monitor: compare every entry due at this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        compare(e, cyc);
      end
    end
  end

  // Between-edge monitor for asynchronous reset behaviour.
  initial begin
    exp_t e;
    forever begin
      @(async_ev);
      if (aq.size() > 0) begin
        e = aq.pop_front();
        compare(e, e.cyc);
      end
    end
  end

  task automatic push_exp(input int n, input logic [7:0] o, input logic [1:0] v,
                          input string nm);
    exp_t e;
    e.cyc = cyc + n; e.out = o; e.ovf = v; e.name = nm;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    Reset = 1'b1; En = 1'b1; Slt = 2'd0; Clr = 1'b0; Mode = 1'b0;
    push_exp(1, 8'h00, 2'b00, "reset_c1");
    push_exp(5, 8'h00, 2'b00, "reset_c5");
    tick(5);

    Reset = 1'b0;
    push_exp(1, 8'h01, 2'b00, "first_edge");
    push_exp(3, 8'h03, 2'b00, "three_edges");
    tick(3);

    Slt = 2'd1;
    push_exp(3,  8'h03, 2'b00, "pre_edge3");
    push_exp(4,  8'h13, 2'b00, "pre_edge4");
    push_exp(8,  8'h23, 2'b00, "pre_edge8");
    push_exp(10, 8'h23, 2'b00, "pre_edge10");
    tick(10);
    Slt = 2'd0;
    push_exp(2, 8'h25, 2'b00, "desel_ch0");
    tick(2);
    Slt = 2'd1;
    push_exp(1, 8'h25, 2'b00, "resume_1");
    push_exp(2, 8'h35, 2'b00, "resume_2");
    tick(2);

    Slt = 2'd3;
    push_exp(3, 8'h35, 2'b00, "slt_oob_en");
    tick(3);
    Clr = 1'b1;
    push_exp(1, 8'h35, 2'b00, "slt_oob_clr");
    tick(1);

    Slt = 2'd0; En = 1'b0;
    push_exp(1, 8'h30, 2'b00, "clr_ch0");
    tick(1);
    Clr = 1'b0; En = 1'b1; Mode = 1'b0;
    push_exp(15, 8'h3f, 2'b00, "wrap_max");
    push_exp(16, 8'h30, 2'b01, "wrap_zero");
    push_exp(17, 8'h31, 2'b01, "wrap_17");
    tick(17);
    En = 1'b0;
    push_exp(5, 8'h31, 2'b01, "ovf_sticky");
    tick(5);

    Clr = 1'b1;
    push_exp(1, 8'h30, 2'b00, "clr_ovf");
    tick(1);
    Clr = 1'b0; En = 1'b1; Mode = 1'b1;
    push_exp(15, 8'h3f, 2'b00, "sat_max");
    push_exp(16, 8'h3f, 2'b01, "sat_hold");
    push_exp(20, 8'h3f, 2'b01, "sat_20");
    tick(20);
    Mode = 1'b0;
    push_exp(1, 8'h30, 2'b01, "mode_to_wrap");
    tick(1);

    push_exp(7, 8'h37, 2'b01, "ch0_seven");
    tick(7);
    Clr = 1'b1;
    push_exp(1, 8'h30, 2'b00, "clr_beats_en");
    tick(1);
    Clr = 1'b0;

    Slt = 2'd1;
    push_exp(3, 8'h30, 2'b00, "pre_at_3");
    tick(3);
    #1;
    Reset = 1'b1;
    #1;
    e.cyc = cyc; e.out = 8'h00; e.ovf = 2'b00; e.name = "async_reset";
    aq.push_back(e);
    -> async_ev;
    #1;
    Reset = 1'b0;
    push_exp(3, 8'h00, 2'b00, "post_rst_3");
    push_exp(4, 8'h10, 2'b00, "post_rst_4");
    tick(4);

    tick(3);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never compared, required at cyc=%0d", e.name, e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/code_counter_bank.md
# code_counter_bank

Parametrised bank of selectable, prescaled event counters; the successor of the two-output Slt/En counter block. It holds CHANNELS independent WIDTH-bit counters. Channel k counts once per 4^k enabled, selected cycles, and adds wrap or saturate overflow handling, sticky overflow flags and a synchronous per-channel clear. It sits beside the datapath as a cycle/event statistics unit and is read through a flat output bus.

## Interface
- WIDTH, 64, bit width of each channel counter (≥2)
- CHANNELS, 2, number of counter channels (1..8)
- SEL_W, 1, width of Slt; must satisfy 2^SEL_W ≥ CHANNELS
- Clk  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-high reset of all state
- En  input  1  count enable for the selected channel
- Slt  input  SEL_W  channel select
- Clr  input  1  synchronous clear of the selected channel
- Mode  input  1  overflow mode: 0 = wrap, 1 = saturate
- Output  output  CHANNELS*WIDTH  counter values; channel k occupies bits [k*WIDTH +: WIDTH]
- Ovf  output  CHANNELS  sticky overflow flag per channel

## Operation
- Per-channel state: count[k] (WIDTH bits), pre[k] (2k bits; channel 0 has no prescaler), ovf[k].
- A channel is active in a cycle when Slt == k. If Slt ≥ CHANNELS, no channel is active and the cycle has no effect.
- Priority on the active channel: Clr, then En, then hold.
- Clr=1: count[k], pre[k] and ovf[k] go to 0 regardless of En. Other channels are unaffected.
- En=1 and Clr=0: pre[k] increments. A count event occurs when pre[k] wraps from 4^k−1 to 0. Channel 0 has a count event every enabled cycle.
- On a count event with count[k] < 2^WIDTH−1: count[k] increments by 1.
- On a count event with count[k] == 2^WIDTH−1:
  - Mode=0: count[k] wraps to 0 and ovf[k] is set.
  - Mode=1: count[k] holds at 2^WIDTH−1 and ovf[k] is set.
- ovf[k] is sticky. Only Clr on that channel or Reset clears it.
- Inactive channels hold count, pre and ovf. A partially advanced prescaler keeps its value while deselected and resumes when reselected.
- Mode is sampled per cycle. Changing Mode never alters a stored count.
- Arithmetic is unsigned, modulo 2^WIDTH for count and modulo 4^k for pre[k].

## Timing
- Reset asserted: all count, pre and ovf go to 0 immediately, without waiting for a clock edge. Output = 0 and Ovf = 0 while Reset is high.
- Reset deassertion takes effect at the next rising edge. The first count can occur on the first edge with Reset low.
- Reset mid-operation (including mid-prescale) discards all partial prescaler progress.
- All outputs are registered. The effect of the inputs sampled at edge n is visible on Output/Ovf after edge n, giving 1-cycle latency. There is no combinational input-to-output path.
- Changing Slt between cycles is allowed every cycle. Each edge updates at most one channel.
- When a count event and Clr coincide, Clr wins: the result is 0 and ovf = 0.
- No handshake is used: En is a level qualifier sampled every edge.

## Test plan
- Reset: hold Reset=1 with En=1, Slt=0 for 5 cycles -> Output=0, Ovf=0. Release Reset; after 3 enabled edges -> channel 0 = 3.
- Prescale (CHANNELS=2): Slt=1, En=1 for 10 edges -> channel 1 = 2 (events at edges 4 and 8), channel 0 unchanged. Set Slt=0 for 2 edges, then Slt=1 for 2 more edges -> channel 1 = 3.
- Wrap (WIDTH=4): Mode=0, Slt=0, En=1 for 17 edges -> channel 0 = 1 and Ovf[0]=1. Ovf[0] is still 1 after 5 further idle cycles.
- Saturate (WIDTH=4): Mode=1, Slt=0, En=1 for 20 edges -> channel 0 = 15 and Ovf[0]=1. Switch to Mode=0 with one more edge -> channel 0 = 0.
- Clear priority: with channel 0 = 7 and Ovf[0]=1, drive Clr=1, En=1, Slt=0 for one edge -> channel 0 = 0, Ovf[0]=0, channel 1 unchanged. Slt=3 with CHANNELS=2 and En=1 -> no channel changes.
- Async reset mid-prescale: with channel 1 prescaler at 3, pulse Reset for 2 ns between edges -> Output drops to 0 before the next edge. The next 3 enabled edges on Slt=1 leave channel 1 = 0, and the 4th edge gives channel 1 = 1.
